// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester handshake bundle for one port of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          stall;

  modport master (output req, we, addr, wdata, input rdata, ack, stall);
  modport slave  (input req, we, addr, wdata, output rdata, ack, stall);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between the core (C) and loader/DMA (D)
module mem_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1,
  parameter int RR     = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  mem_port_arbiter_if.slave c_if,
  mem_port_arbiter_if.slave d_if,
  output logic              m_en,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  input  logic [DW-1:0]     m_rdata,
  output logic              busy,
  output logic              gnt_d
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          win;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    win       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_if.req || d_if.req) begin
          // D wins when alone, or on contention only if round-robin says it is D's turn
          win     = d_if.req && (!c_if.req || ((RR != 0) && prio_q));
          owner_d = win;
          we_d    = win ? d_if.we    : c_if.we;
          addr_d  = win ? d_if.addr  : c_if.addr;
          wdata_d = win ? d_if.wdata : c_if.wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (owner_q) d_rdata_d = m_rdata;
          else         c_rdata_d = m_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (RR != 0) prio_d = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_en    = (state_q == S_ACCESS);
  assign m_we    = m_en && we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state_q != S_IDLE);
  assign gnt_d   = owner_q;

  assign c_if.ack   = (state_q == S_DONE) && !owner_q;
  assign d_if.ack   = (state_q == S_DONE) && owner_q;
  assign c_if.rdata = c_rdata_q;
  assign d_if.rdata = d_rdata_q;
  assign c_if.stall = c_if.req && !c_if.ack;
  assign d_if.stall = d_if.req && !d_if.ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench: dut_a RR=1/RD_LAT=2, dut_b RR=0/RD_LAT=3
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(16), .DW(16)) ca ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) da ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) cb ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) db ();

  logic        am_en, am_we, a_busy, a_gnt;
  logic [15:0] am_addr, am_wdata, am_rdata;
  logic        bm_en, bm_we, b_busy, b_gnt;
  logic [15:0] bm_addr, bm_wdata, bm_rdata;

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(2), .RR(1)) dut_a (
    .CLK(CLK), .Reset(rst_a), .c_if(ca), .d_if(da),
    .m_en(am_en), .m_we(am_we), .m_addr(am_addr), .m_wdata(am_wdata),
    .m_rdata(am_rdata), .busy(a_busy), .gnt_d(a_gnt)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .RR(0)) dut_b (
    .CLK(CLK), .Reset(rst_b), .c_if(cb), .d_if(db),
    .m_en(bm_en), .m_we(bm_we), .m_addr(bm_addr), .m_wdata(bm_wdata),
    .m_rdata(bm_rdata), .busy(b_busy), .gnt_d(b_gnt)
  );

  // Memory models: read data appears exactly RD_LAT cycles after the m_en cycle
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [7:0]  pa [0:1];
  logic [7:0]  pb [0:2];
  logic        bd_wa, bd_wb;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge CLK) begin
    if (bd_wa) mem_a[bd_addr] <= bd_data;
    if (am_en && am_we) mem_a[am_addr[7:0]] <= am_wdata;
    pa[0] <= am_addr[7:0];
    pa[1] <= pa[0];
    if (bd_wb) mem_b[bd_addr] <= bd_data;
    if (bm_en && bm_we) mem_b[bm_addr[7:0]] <= bm_wdata;
    pb[0] <= bm_addr[7:0];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign am_rdata = mem_a[pa[1]];
  assign bm_rdata = mem_b[pb[2]];

  // Event log: grant owner of every ack (0 = C, 1 = D), m_en count, ack overlap
  bit log_a[$];
  bit log_b[$];
  int men_a = 0, men_b = 0, ovl = 0;
  int ack_cyc_a = 0, ack_cyc_b = 0, men_cyc_a = 0;

  always @(negedge CLK) begin
    if (am_en) begin
      men_a     <= men_a + 1;
      men_cyc_a <= cyc;
    end
    if (bm_en) men_b <= men_b + 1;
    if (ca.ack) begin log_a.push_back(1'b0); ack_cyc_a <= cyc; end
    if (da.ack) begin log_a.push_back(1'b1); ack_cyc_a <= cyc; end
    if (cb.ack) begin log_b.push_back(1'b0); ack_cyc_b <= cyc; end
    if (db.ack) begin log_b.push_back(1'b1); ack_cyc_b <= cyc; end
    if ((ca.ack && da.ack) || (cb.ack && db.ack)) ovl <= ovl + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nstep(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic wait_ack(input bit sel, input int n, input string tag);
    int k = 0;
    while (((sel ? log_b.size() : log_a.size()) < n) && (k < 80)) begin
      nstep(1);
      k++;
    end
    check(tag, sel ? log_b.size() : log_a.size(), n);
  endtask

  task automatic bd_write(input bit sel, input logic [7:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    bd_wa   = !sel;
    bd_wb   = sel;
    nstep(1);
    bd_wa   = 1'b0;
    bd_wb   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int t0, m0, n0;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bd_wa = 1'b0; bd_wb = 1'b0; bd_addr = '0; bd_data = '0;
    ca.req = 0; ca.we = 0; ca.addr = '0; ca.wdata = '0;
    da.req = 0; da.we = 0; da.addr = '0; da.wdata = '0;
    cb.req = 0; cb.we = 0; cb.addr = '0; cb.wdata = '0;
    db.req = 0; db.we = 0; db.addr = '0; db.wdata = '0;
    nstep(1);

    check("rst_men_a", am_en, 0);
    check("rst_busy_a", a_busy, 0);
    check("rst_gnt_a", a_gnt, 0);
    check("rst_crd_a", ca.rdata, 0);
    check("rst_drd_a", da.rdata, 0);
    check("rst_cack_a", ca.ack, 0);
    check("rst_men_b", bm_en, 0);
    check("rst_busy_b", b_busy, 0);

    bd_write(1'b0, 8'h10, 16'hBEEF);
    bd_write(1'b1, 8'h10, 16'hC0DE);
    bd_write(1'b1, 8'h20, 16'hD00D);
    rst_a = 1'b0; rst_b = 1'b0;
    nstep(1);

    // 1: C read, RD_LAT=2
    ca.we = 1'b0; ca.addr = 16'h0010; ca.req = 1'b1;
    t0 = cyc; m0 = men_a;
    #1;
    check("t1_stall_idle", ca.stall, 1);
    nstep(1);
    check("t1_men", am_en, 1);
    check("t1_maddr", am_addr, 16'h0010);
    check("t1_mwe", am_we, 0);
    wait_ack(1'b0, 1, "t1_ack");
    check("t1_lat", ack_cyc_a - t0, 4);
    check("t1_men_cyc", men_cyc_a - t0, 1);
    check("t1_rdata", ca.rdata, 16'hBEEF);
    check("t1_stall_ack", ca.stall, 0);
    nstep(1);
    ca.req = 1'b0;
    nstep(3);
    check("t1_hold", ca.rdata, 16'hBEEF);
    check("t1_idle", a_busy, 0);
    check("t1_men_cnt", men_a - m0, 1);

    // 2: D write then read back
    da.we = 1'b1; da.addr = 16'h0042; da.wdata = 16'h1234; da.req = 1'b1;
    nstep(1);
    check("t2_men", am_en, 1);
    check("t2_mwe", am_we, 1);
    check("t2_maddr", am_addr, 16'h0042);
    check("t2_mwdata", am_wdata, 16'h1234);
    nstep(1);
    check("t2_dack", da.ack, 1);
    check("t2_gnt", a_gnt, 1);
    nstep(1);
    da.req = 1'b0; da.we = 1'b0;
    nstep(1);
    da.req = 1'b1; t0 = cyc;
    wait_ack(1'b0, 3, "t2_rd_ack");
    check("t2_rd_lat", ack_cyc_a - t0, 4);
    check("t2_rdata", da.rdata, 16'h1234);
    check("t2_c_untouched", ca.rdata, 16'hBEEF);
    nstep(1);
    da.req = 1'b0;
    nstep(2);

    // 3: RR=1, both requesting continuously from reset
    rst_a = 1'b1;
    ca.we = 1'b0; ca.addr = 16'h0010; ca.req = 1'b1;
    da.we = 1'b0; da.addr = 16'h0042; da.req = 1'b1;
    nstep(1);
    rst_a = 1'b0;
    n0 = log_a.size(); m0 = men_a;
    wait_ack(1'b0, n0 + 4, "t3_acks");
    for (int i = 0; i < 4; i++) check("t3_grant", log_a[n0 + i], i % 2);
    check("t3_men", men_a - m0, 4);
    check("t3_overlap", ovl, 0);
    check("t3_crd", ca.rdata, 16'hBEEF);
    check("t3_drd", da.rdata, 16'h1234);
    nstep(1);
    ca.req = 1'b0; da.req = 1'b0;
    nstep(2);

    // 6: C drops req mid-WAIT
    ca.we = 1'b0; ca.addr = 16'h0042; ca.req = 1'b1;
    t0 = cyc; m0 = men_a; n0 = log_a.size();
    nstep(2);
    ca.req = 1'b0; ca.addr = 16'h0099;
    check("t6_busy", a_busy, 1);
    wait_ack(1'b0, n0 + 1, "t6_ack");
    check("t6_lat", ack_cyc_a - t0, 4);
    check("t6_rdata", ca.rdata, 16'h1234);
    check("t6_owner", log_a[n0], 0);
    nstep(4);
    check("t6_men_cnt", men_a - m0, 1);
    check("t6_no_retry", log_a.size(), n0 + 1);
    check("t6_idle", a_busy, 0);

    // 4: RR=0, C starves D until it lets go
    cb.we = 1'b0; cb.addr = 16'h0010; cb.req = 1'b1;
    db.we = 1'b0; db.addr = 16'h0020; db.req = 1'b1;
    n0 = log_b.size();
    wait_ack(1'b1, n0 + 3, "t4_acks");
    for (int i = 0; i < 3; i++) check("t4_c_wins", log_b[n0 + i], 0);
    check("t4_crd", cb.rdata, 16'hC0DE);
    check("t4_d_starved", db.rdata, 0);
    nstep(1);
    cb.req = 1'b0;
    wait_ack(1'b1, n0 + 4, "t4_d_ack");
    check("t4_d_next", log_b[n0 + 3], 1);
    check("t4_drd", db.rdata, 16'hD00D);
    check("t4_gnt", b_gnt, 1);
    check("t4_overlap", ovl, 0);
    nstep(1);
    db.req = 1'b0;
    nstep(2);

    // 5: RD_LAT=3, Reset during WAIT aborts the D read
    rst_b = 1'b1;
    nstep(1);
    rst_b = 1'b0;
    nstep(1);
    check("t5_drd_rst", db.rdata, 0);
    db.we = 1'b0; db.addr = 16'h0020; db.req = 1'b1;
    n0 = log_b.size(); m0 = men_b;
    nstep(2);
    check("t5_busy_wait", b_busy, 1);
    rst_b = 1'b1;
    #1;
    check("t5_men", bm_en, 0);
    check("t5_busy", b_busy, 0);
    check("t5_drd", db.rdata, 0);
    db.req = 1'b0;
    nstep(1);
    rst_b = 1'b0;
    nstep(5);
    check("t5_no_ack", log_b.size(), n0);
    check("t5_drd_after", db.rdata, 0);
    cb.we = 1'b0; cb.addr = 16'h0010; cb.req = 1'b1;
    t0 = cyc;
    wait_ack(1'b1, n0 + 1, "t5_c_ack");
    check("t5_c_lat", ack_cyc_b - t0, 5);
    check("t5_c_owner", log_b[n0], 0);
    check("t5_crd", cb.rdata, 16'hC0DE);
    check("t5_men_cnt", men_b - m0, 2);
    nstep(1);
    cb.req = 1'b0;
    nstep(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
